gate_delay_pipe: RTL and testbench

Cycle-accurate, parametrised model of the reference three-gate network, with the per-gate delays expressed in clock cycles instead of simulation time units. The network is e = A & B, y = ~C, x = e | y. The block processes WIDTH independent lanes and supports two delay modes per build: transport (pure pipeline) and inertial (pulses shorter than a gate's latency are suppressed). It sits alongside the gate-level delay models as their synthesizable, clocked successor and is driven by the same kind of directed stimulus benches.

---
 rtl/gdp_pkg.sv | 18 +
 rtl/gate_delay_pipe_delay_elem.sv | 108 ++++++++++
 rtl/gate_delay_pipe.sv | 91 +++++++++
 tb/tb_gate_delay_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gdp_pkg.sv
// Shared constants and elaboration helpers for the clocked gate-delay pipeline.
// Holds the latency limits, the delay-mode encodings and the counter sizing rule.
package gdp_pkg;

    localparam int MAX_LAT        = 15;
    localparam int MODE_TRANSPORT = 0;
    localparam int MODE_INERTIAL  = 1;

    // Width of an inertial counter that must reach LAT-1; never narrower than one bit.
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

    function automatic bit lat_in_range(input int lat);
        return (lat >= 1) && (lat <= MAX_LAT);
    endfunction

endpackage

// File: rtl/gate_delay_pipe_delay_elem.sv
// One gate's delay element: d is the already-computed gate function, q its delayed copy.
// Latency LAT cycles; no backpressure, takes a new d every cycle; idle is combinational.
module delay_elem
    import gdp_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LAT      = 1,
    parameter int INERTIAL = MODE_TRANSPORT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             idle
);

    if (INERTIAL == MODE_INERTIAL && LAT > 1) begin : g_inertial
        localparam int             CW      = cnt_width(LAT);
        localparam logic [CW-1:0]  CNT_TOP = CW'(LAT - 1);

        logic [WIDTH-1:0] out_q, out_d;
        logic [CW-1:0]    cnt_q [WIDTH];
        logic [CW-1:0]    cnt_d [WIDTH];

        // A lane only flips once d has disagreed with out for LAT consecutive samples.
        always_comb begin
            out_d = out_q;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_d[i] = '0;
                if (d[i] != out_q[i]) begin
                    if (cnt_q[i] == CNT_TOP) begin
                        out_d[i] = d[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
            end
            if (flush) begin
                out_d = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_d[i] = '0;
                end
            end
        end

        always_comb begin
            idle = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
                if (cnt_q[i] != '0 || d[i] != out_q[i]) begin
                    idle = 1'b0;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q <= '0;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_q[i] <= '0;
                end
            end else begin
                out_q <= out_d;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_q[i] <= cnt_d[i];
                end
            end
        end

        assign q = out_q;

    end else begin : g_transport
        logic [WIDTH-1:0] stage_q [LAT];
        logic [WIDTH-1:0] stage_d [LAT];

        always_comb begin
            stage_d[0] = flush ? '0 : d;
            for (int i = 1; i < LAT; i++) begin
                stage_d[i] = flush ? '0 : stage_q[i-1];
            end
        end

        // Idle only when every queued sample already equals the present gate value.
        always_comb begin
            idle = 1'b1;
            for (int i = 0; i < LAT; i++) begin
                if (stage_q[i] != d) begin
                    idle = 1'b0;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < LAT; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < LAT; i++) begin
                    stage_q[i] <= stage_d[i];
                end
            end
        end

        assign q = stage_q[LAT-1];
    end

endmodule

// File: rtl/gate_delay_pipe.sv
// Clocked three-gate network per lane: e = a & b, y = ~c, x = e | y, each gate a delay element.
// Latency c->y NOT_LAT, c->x NOT_LAT+OR_LAT, a/b->x AND_LAT+OR_LAT; no backpressure.
module gate_delay_pipe
    import gdp_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int AND_LAT  = 3,
    parameter int NOT_LAT  = 1,
    parameter int OR_LAT   = 2,
    parameter int INERTIAL = MODE_TRANSPORT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             settled
);

    if (!lat_in_range(AND_LAT)) begin : g_bad_and_lat
        $error("gate_delay_pipe: AND_LAT must be 1..15");
    end
    if (!lat_in_range(NOT_LAT)) begin : g_bad_not_lat
        $error("gate_delay_pipe: NOT_LAT must be 1..15");
    end
    if (!lat_in_range(OR_LAT)) begin : g_bad_or_lat
        $error("gate_delay_pipe: OR_LAT must be 1..15");
    end
    if (INERTIAL != MODE_TRANSPORT && INERTIAL != MODE_INERTIAL) begin : g_bad_mode
        $error("gate_delay_pipe: INERTIAL must be 0 or 1");
    end

    logic [WIDTH-1:0] and_f, not_f, or_f;
    logic [WIDTH-1:0] e_q, y_q, x_q;
    logic             and_idle, not_idle, or_idle;
    logic             settled_q, settled_d;

    // The OR gate sees the delayed AND/NOT outputs, so reconvergent skew shows up here.
    always_comb begin
        and_f = a & b;
        not_f = ~c;
        or_f  = e_q | y_q;
    end

    delay_elem #(.WIDTH(WIDTH), .LAT(AND_LAT), .INERTIAL(INERTIAL)) u_and (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .d     (and_f),
        .q     (e_q),
        .idle  (and_idle)
    );

    delay_elem #(.WIDTH(WIDTH), .LAT(NOT_LAT), .INERTIAL(INERTIAL)) u_not (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .d     (not_f),
        .q     (y_q),
        .idle  (not_idle)
    );

    delay_elem #(.WIDTH(WIDTH), .LAT(OR_LAT), .INERTIAL(INERTIAL)) u_or (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .d     (or_f),
        .q     (x_q),
        .idle  (or_idle)
    );

    always_comb begin
        settled_d = ~flush & and_idle & not_idle & or_idle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settled_q <= 1'b0;
        end else begin
            settled_q <= settled_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign settled = settled_q;

endmodule

// File: tb/tb_gate_delay_pipe.sv
// Three configurations of gate_delay_pipe driven in lockstep, checked against a sample-history model.
// Directed test-plan sequences first, then randomized lane toggles with occasional flush and reset.
module tb_gate_delay_pipe;

    localparam int W    = 4;
    localparam int N    = 3;
    localparam int HMAX = 16;
    localparam int AND_L [N] = '{3, 3, 3};
    localparam int NOT_L [N] = '{1, 1, 3};
    localparam int OR_L  [N] = '{2, 3, 2};
    localparam int INER  [N] = '{0, 1, 1};
    localparam logic [W-1:0] ALL1 = '1;

    logic         clk, rst_n, flush;
    logic [W-1:0] a, b, c;
    logic [W-1:0] x_o [N];
    logic [W-1:0] y_o [N];
    logic         s_o [N];

    for (genvar k = 0; k < N; k++) begin : g_dut
        gate_delay_pipe #(
            .WIDTH    (W),
            .AND_LAT  (AND_L[k]),
            .NOT_LAT  (NOT_L[k]),
            .OR_LAT   (OR_L[k]),
            .INERTIAL (INER[k])
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (flush),
            .a       (a),
            .b       (b),
            .c       (c),
            .x       (x_o[k]),
            .y       (y_o[k]),
            .settled (s_o[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: per gate, the history of sampled gate values (index 0 newest).
    // Transport output is the sample LAT edges old; inertial output takes a value
    // only once the last LAT samples all agree on it.
    logic [W-1:0] hist  [N][3][HMAX];
    logic [W-1:0] m_out [N][3];
    logic         m_set [N];
    int           n_chk, n_pass, cyc;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic int lat_of(input int k, input int el);
        case (el)
            0:       return AND_L[k];
            1:       return NOT_L[k];
            default: return OR_L[k];
        endcase
    endfunction

    task automatic model_clear(input int k);
        for (int el = 0; el < 3; el++) begin
            for (int j = 0; j < HMAX; j++) hist[k][el][j] = '0;
            m_out[k][el] = '0;
        end
        m_set[k] = 1'b0;
    endtask

    task automatic model_step(input int k);
        logic [W-1:0] din [3];
        logic         all_idle, ones, zeros;
        int           lat;
        if (!rst_n || flush) begin
            model_clear(k);
            return;
        end
        din[0] = a & b;
        din[1] = ~c;
        din[2] = m_out[k][0] | m_out[k][1];
        all_idle = 1'b1;
        for (int el = 0; el < 3; el++) begin
            lat = lat_of(k, el);
            if (INER[k] == 0) begin
                for (int j = 0; j < lat; j++)
                    if (hist[k][el][j] != din[el]) all_idle = 1'b0;
            end else begin
                if (m_out[k][el] != din[el] || hist[k][el][0] != m_out[k][el]) all_idle = 1'b0;
            end
        end
        m_set[k] = all_idle;
        for (int el = 0; el < 3; el++) begin
            lat = lat_of(k, el);
            for (int j = HMAX - 1; j > 0; j--) hist[k][el][j] = hist[k][el][j-1];
            hist[k][el][0] = din[el];
            if (INER[k] == 0) begin
                m_out[k][el] = hist[k][el][lat-1];
            end else begin
                for (int w = 0; w < W; w++) begin
                    ones  = 1'b1;
                    zeros = 1'b1;
                    for (int j = 0; j < lat; j++) begin
                        if (hist[k][el][j][w]) zeros = 1'b0;
                        else                   ones  = 1'b0;
                    end
                    if (ones)  m_out[k][el][w] = 1'b1;
                    if (zeros) m_out[k][el][w] = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("x%0d", k), x_o[k], m_out[k][2]);
            chk($sformatf("y%0d", k), y_o[k], m_out[k][1]);
            chk($sformatf("settled%0d", k), W'(s_o[k]), W'(m_set[k]));
        end
    endtask

    task automatic tick();
        for (int k = 0; k < N; k++) model_step(k);
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) model_clear(k);
        #1;
        compare_all();
        tick();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0;
        rst_n = 1'b1; flush = 1'b0;
        a = '0; b = '0; c = '0;
        #2;
        do_reset();
        chk("rst_x", x_o[0], '0);
        chk("rst_settled", W'(s_o[0]), '0);

        // Power-up with a=b=c=0, then all inputs to F at cycle 10.
        for (int n = 1; n <= 20; n++) begin
            if (n == 11) begin a = ALL1; b = ALL1; c = ALL1; end
            tick();
            if (n == 1)  chk("y_from_c1", y_o[0], ALL1);
            if (n == 2)  chk("x_before_c3", x_o[0], '0);
            if (n == 3)  begin chk("x_from_c3", x_o[0], ALL1); chk("settled_c3", W'(s_o[0]), '0); end
            if (n == 4)  chk("settled_c4", W'(s_o[0]), 1);
            if (n == 11) begin
                chk("y_c11", y_o[0], '0);
                chk("settled_drop", W'(s_o[0]), '0);
                chk("settled_drop_inert", W'(s_o[1]), '0);
            end
            if (n == 13 || n == 14) chk("x_hazard", x_o[0], '0);
            if (n == 15) begin chk("x_c15", x_o[0], ALL1); chk("settled_c15", W'(s_o[0]), '0); end
            if (n == 16) chk("settled_c16", W'(s_o[0]), 1);
            if (n >= 11) chk("x_inert_no_hazard", x_o[1], ALL1);
            if (n == 20) chk("settled_inert_back", W'(s_o[1]), 1);
        end

        // Inertial NOT_LAT=3: pulses on lane 0 of c.
        a = '0; b = '0; c = '0;
        repeat (10) tick();
        c = 4'b0001;
        for (int n = 1; n <= 8; n++) begin
            if (n == 3) c = '0;
            tick();
            chk("y_short_pulse", y_o[2], ALL1);
        end
        c = 4'b0001;
        for (int n = 1; n <= 7; n++) begin
            if (n == 4) c = '0;
            tick();
            chk("y_long_pulse", y_o[2], (n >= 3 && n <= 5) ? 4'b1110 : ALL1);
        end

        // Asynchronous reset two cycles after a step.
        repeat (4) tick();
        a = ALL1; b = ALL1; c = ALL1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_x", x_o[0], '0);
        chk("arst_y", y_o[0], '0);
        chk("arst_settled", W'(s_o[0]), '0);
        for (int k = 0; k < N; k++) model_clear(k);
        tick();
        rst_n = 1'b1;
        cyc = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            chk("no_stale_y", y_o[0], '0);
        end

        // Flush while a transition is in flight.
        a = '0; c = '0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk("flush_x", x_o[k], '0);
            chk("flush_y", y_o[k], '0);
            chk("flush_settled", W'(s_o[k]), '0);
        end
        repeat (12) tick();

        // Randomized lane toggles with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            a = a ^ (W'($urandom) & W'($urandom));
            b = b ^ (W'($urandom) & W'($urandom));
            c = c ^ (W'($urandom) & W'($urandom));
            flush = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0) begin
                flush = 1'b0;
                do_reset();
            end else begin
                tick();
            end
        end
        flush = 1'b0;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
